npu_result_collector: RTL and testbench

Output stage directly downstream of the 4x4 systolic NPU array. Each array column emits its result lane one cycle later than the column before it. This block removes that skew, assembles each result as one aligned 4-lane vector, and buffers vectors in a small FIFO. Consumers read vectors through a valid/ready handshake, with per-frame end marking.

---
 rtl/npu_result_collector.sv | 214 +++++++++++++++++++++
 tb/tb_npu_result_collector.sv | 290 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/npu_result_collector.sv
// -----------------------------------------------------------------------------
// npu_result_collector
//
// Output stage of the 4x4 systolic NPU array. Column j of the array emits
// lane j of a result j cycles after lane 0. This block:
//   1. deskews the four lanes back into one aligned vector,
//   2. pushes each aligned vector into a small FIFO (the upstream array cannot
//      be stalled, so a vector arriving at a full FIFO with no pop is dropped
//      and a sticky overflow flag is raised),
//   3. presents the FIFO head through a valid/ready handshake and marks the
//      last vector of every FRAME_LEN-vector frame.
//
// Optional build macro:
//   NPU_COLLECT_RELU_EN - when defined, every lane with its sign bit set is
//                         written to the FIFO as zero (ReLU). When undefined,
//                         lanes are stored bit-exact.
//
// Parameters:
//   WIDTH     - bits per lane (4 lanes, fixed)
//   DEPTH     - FIFO entries, power of two, >= 2
//   FRAME_LEN - vectors per frame
//
// Ports:
//   clk         in   rising-edge clock
//   rst         in   synchronous, active-low reset
//   in_valid    in   lane 0 of in_data starts a new result vector this cycle
//   in_data     in   [4][WIDTH] array column outputs, lane j skewed by j cycles
//   out_valid   out  FIFO head holds a vector
//   out_ready   in   consumer accepts the head this cycle
//   out_data    out  [4][WIDTH] head vector, all-zero when out_valid=0
//   out_last    out  head is the last vector of the current frame
//   frame_done  out  one-cycle pulse after the last vector of a frame is popped
//   level       out  FIFO occupancy
//   overflow    out  sticky: a vector was dropped because the FIFO was full
// -----------------------------------------------------------------------------
module npu_result_collector #(
    parameter int WIDTH     = 16,
    parameter int DEPTH     = 4,
    parameter int FRAME_LEN = 5
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic                         in_valid,
    input  logic [3:0][WIDTH-1:0]        in_data,
    output logic                         out_valid,
    input  logic                         out_ready,
    output logic [3:0][WIDTH-1:0]        out_data,
    output logic                         out_last,
    output logic                         frame_done,
    output logic [$clog2(DEPTH+1)-1:0]   level,
    output logic                         overflow
);

    localparam int LANES = 4;
    localparam int PW    = $clog2(DEPTH);
    localparam int LW    = $clog2(DEPTH + 1);
    localparam int FCW   = (FRAME_LEN > 1) ? $clog2(FRAME_LEN) : 1;

    localparam logic [LW-1:0]  FULL_LEVEL = LW'(DEPTH);
    localparam logic [FCW-1:0] LAST_CNT   = FCW'(FRAME_LEN - 1);

    typedef logic [LANES-1:0][WIDTH-1:0] vec_t;

    // -------------------------------------------------------------------------
    // Deskew pipeline
    //
    // Lane j needs (3-j) register stages so that all four lanes of a vector
    // line up in the cycle its lane 3 arrives. in_valid rides along the
    // longest (lane 0) path and becomes the push strobe.
    // -------------------------------------------------------------------------
    logic [WIDTH-1:0] lane0_q [3];
    logic [WIDTH-1:0] lane1_q [2];
    logic [WIDTH-1:0] lane2_q;
    logic [2:0]       valid_q;

    // NOTE: sequential state uses non-blocking (<=) so every register samples
    // the pre-edge value of its neighbour; blocking here would collapse the
    // shift chain into a single stage.
    always_ff @(posedge clk) begin
        if (!rst) begin
            lane0_q[0] <= '0;
            lane0_q[1] <= '0;
            lane0_q[2] <= '0;
            lane1_q[0] <= '0;
            lane1_q[1] <= '0;
            lane2_q    <= '0;
            valid_q    <= '0;
        end else begin
            lane0_q[0] <= in_data[0];
            lane0_q[1] <= lane0_q[0];
            lane0_q[2] <= lane0_q[1];
            lane1_q[0] <= in_data[1];
            lane1_q[1] <= lane1_q[0];
            lane2_q    <= in_data[2];
            valid_q    <= {valid_q[1:0], in_valid};
        end
    end

    logic push;
    vec_t aligned_vec;

    // Lane 3 is the youngest lane; it is used straight from the input.
    assign aligned_vec = {in_data[3], lane2_q, lane1_q[1], lane0_q[2]};
    assign push        = valid_q[2];

    // -------------------------------------------------------------------------
    // Write-data conditioning (optional ReLU)
    // -------------------------------------------------------------------------
    function automatic logic [WIDTH-1:0] store_lane(input logic [WIDTH-1:0] v);
`ifdef NPU_COLLECT_RELU_EN
        // Negative two's-complement values clamp to zero.
        return v[WIDTH-1] ? '0 : v;
`else
        return v;
`endif
    endfunction

    vec_t wr_vec;

    // NOTE: every combinational output gets a default before any conditional
    // logic, so no path leaves it unassigned and no latch is inferred.
    always_comb begin
        wr_vec = '0;
        for (int j = 0; j < LANES; j++) begin
            wr_vec[j] = store_lane(aligned_vec[j]);
        end
    end

    // -------------------------------------------------------------------------
    // FIFO
    // -------------------------------------------------------------------------
    vec_t            mem [DEPTH];
    logic [PW-1:0]   wr_ptr;
    logic [PW-1:0]   rd_ptr;
    logic [FCW-1:0]  frame_cnt;

    logic pop;
    logic full;
    logic push_accept;
    logic drop;

    assign out_valid   = (level != '0);
    assign full        = (level == FULL_LEVEL);
    // out_valid does not depend on out_ready, so pop has no combinational
    // loop back into the handshake.
    assign pop         = out_valid && out_ready;
    // A pop in the same cycle frees the slot, so a full FIFO still accepts.
    assign push_accept = push && (!full || pop);
    assign drop        = push && full && !pop;

    assign out_data    = out_valid ? mem[rd_ptr] : '0;
    assign out_last    = out_valid && (frame_cnt == LAST_CNT);

    // NOTE: the storage array carries data only; occupancy lives in level and
    // the pointers, so the array needs no reset and can map onto plain RAM.
    always_ff @(posedge clk) begin
        if (push_accept) begin
            mem[wr_ptr] <= wr_vec;
        end
    end

    // Pointers wrap naturally because DEPTH is a power of two.
    always_ff @(posedge clk) begin
        if (!rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            level  <= '0;
        end else begin
            if (push_accept) begin
                wr_ptr <= wr_ptr + PW'(1);
            end
            if (pop) begin
                rd_ptr <= rd_ptr + PW'(1);
            end
            case ({push_accept, pop})
                2'b10:   level <= level + LW'(1);
                2'b01:   level <= level - LW'(1);
                default: level <= level;
            endcase
        end
    end

    // -------------------------------------------------------------------------
    // Overflow and frame tracking
    //
    // Dropped vectors never reach the FIFO, so they never count toward a
    // frame; the frame counter advances on pops only.
    // -------------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (!rst) begin
            overflow   <= 1'b0;
            frame_cnt  <= '0;
            frame_done <= 1'b0;
        end else begin
            if (drop) begin
                overflow <= 1'b1;
            end
            if (pop) begin
                frame_cnt <= out_last ? '0 : frame_cnt + FCW'(1);
            end
            frame_done <= pop && out_last;
        end
    end

    // -------------------------------------------------------------------------
    // Design invariants
    // -------------------------------------------------------------------------
    a_level_bound : assert property (@(posedge clk) disable iff (!rst)
        level <= FULL_LEVEL);

    a_head_stable : assert property (@(posedge clk) disable iff (!rst)
        (out_valid && !out_ready) |=> (out_valid && $stable(out_data)));

endmodule

// File: tb/tb_npu_result_collector.sv
// -----------------------------------------------------------------------------
// tb_npu_result_collector
//
// Directed bench for npu_result_collector. A queue-based reference model
// predicts every output on every cycle; a compare process checks the DUT
// against it on the falling edge. Hand-computed literal checks in the
// stimulus sequence pin the model itself.
// -----------------------------------------------------------------------------
module tb_npu_result_collector;

    localparam int W     = 16;
    localparam int DEPTH = 4;
    localparam int FL    = 5;
    localparam int LW    = $clog2(DEPTH + 1);

    typedef logic [3:0][W-1:0] vec_t;

    logic          clk = 1'b0;
    logic          rst = 1'b0;
    logic          in_valid = 1'b0;
    vec_t          in_data = '0;
    logic          out_ready = 1'b0;
    logic          out_valid;
    vec_t          out_data;
    logic          out_last;
    logic          frame_done;
    logic [LW-1:0] level;
    logic          overflow;

    int n_vec = 0;
    int n_err = 0;

    always #5 clk = ~clk;

    npu_result_collector #(
        .WIDTH    (W),
        .DEPTH    (DEPTH),
        .FRAME_LEN(FL)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_data   (in_data),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (out_data),
        .out_last  (out_last),
        .frame_done(frame_done),
        .level     (level),
        .overflow  (overflow)
    );

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic vec_t mk(input int k);
        vec_t v;
        for (int j = 0; j < 4; j++) v[j] = W'(k * 16 + j);
        return v;
    endfunction

    function automatic vec_t relu(input vec_t v);
        vec_t r;
        r = v;
`ifdef NPU_COLLECT_RELU_EN
        for (int j = 0; j < 4; j++) if (v[j][W-1]) r[j] = '0;
`endif
        return r;
    endfunction

    // -------------------------------------------------------------------------
    // Reference model: input history -> assembled vectors -> FIFO queue
    // -------------------------------------------------------------------------
    vec_t mq[$];
    int   m_fcnt   = 0;
    bit   m_ovf    = 1'b0;
    bit   m_fd     = 1'b0;
    bit   model_ok = 1'b0;
    int   cyc      = 0;
    int   last_rst = -100;
    bit   hist_v [8];
    vec_t hist_d [8];

    always @(posedge clk) begin : model
        bit   m_pop;
        bit   m_push;
        bit   m_last_pop;
        vec_t v;
        hist_v[cyc % 8] = in_valid;
        hist_d[cyc % 8] = in_data;
        if (!rst) begin
            mq.delete();
            m_fcnt   = 0;
            m_ovf    = 1'b0;
            m_fd     = 1'b0;
            last_rst = cyc;
            model_ok = 1'b1;
        end else begin
            // A vector started at cycle s completes at s+3 with lane j taken at s+j.
            m_push = (cyc >= 3) && hist_v[(cyc - 3) % 8] && ((cyc - 3) > last_rst);
            v = '0;
            if (m_push) begin
                for (int j = 0; j < 4; j++) v[j] = hist_d[(cyc - 3 + j) % 8][j];
                v = relu(v);
            end
            m_pop      = (mq.size() > 0) && out_ready;
            m_last_pop = m_pop && (m_fcnt == FL - 1);
            if (m_pop) begin
                void'(mq.pop_front());
                m_fcnt = m_last_pop ? 0 : m_fcnt + 1;
            end
            if (m_push) begin
                if (mq.size() < DEPTH) mq.push_back(v);
                else m_ovf = 1'b1;
            end
            m_fd = m_last_pop;
        end
        cyc++;
    end

    always @(negedge clk) begin : compare
        bit e_valid;
        if (model_ok) begin
            e_valid = mq.size() > 0;
            check("out_valid",  64'(out_valid),  64'(e_valid));
            check("out_data",   64'(out_data),   e_valid ? 64'(mq[0]) : 64'd0);
            check("out_last",   64'(out_last),   64'(e_valid && (m_fcnt == FL - 1)));
            check("level",      64'(level),      64'(mq.size()));
            check("overflow",   64'(overflow),   64'(m_ovf));
            check("frame_done", 64'(frame_done), 64'(m_fd));
        end
    end

    // -------------------------------------------------------------------------
    // Skewed driver: lane j of a vector is presented j cycles after in_valid.
    // Lanes with nothing scheduled carry random junk.
    // -------------------------------------------------------------------------
    vec_t d_vec [4];
    bit   d_act [4];

    task automatic tick(input bit v, input vec_t vec, input bit rdy);
        for (int a = 3; a > 0; a--) begin
            d_act[a] = d_act[a-1];
            d_vec[a] = d_vec[a-1];
        end
        d_act[0] = v;
        d_vec[0] = vec;
        in_valid = v;
        for (int j = 0; j < 4; j++) in_data[j] = d_act[j] ? d_vec[j][j] : W'($urandom);
        out_ready = rdy;
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset(input bit rdy);
        rst = 1'b0;
        tick(1'b0, '0, rdy);
        rst = 1'b1;
    endtask

    initial begin : watchdog
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin : stim
        int   pops;
        int   fd_seen;
        bit   prev_last_pop;
        vec_t rv;
        for (int a = 0; a < 4; a++) begin
            d_act[a] = 1'b0;
            d_vec[a] = '0;
        end

        // Reset state
        rst = 1'b0;
        tick(1'b0, '0, 1'b0);
        tick(1'b0, '0, 1'b0);
        rst = 1'b1;
        check("rst_out_valid",  64'(out_valid),  64'd0);
        check("rst_out_data",   64'(out_data),   64'd0);
        check("rst_level",      64'(level),      64'd0);
        check("rst_overflow",   64'(overflow),   64'd0);
        check("rst_frame_done", 64'(frame_done), 64'd0);

        // Skew alignment: lanes 1,2,3,4; visible 4 cycles after in_valid
        tick(1'b1, {16'd4, 16'd3, 16'd2, 16'd1}, 1'b1);
        tick(1'b0, '0, 1'b1);
        tick(1'b0, '0, 1'b1);
        check("skew_not_yet", 64'(out_valid), 64'd0);
        tick(1'b0, '0, 1'b1);
        check("skew_valid", 64'(out_valid), 64'd1);
        check("skew_data",  64'(out_data),  64'h0004_0003_0002_0001);
        tick(1'b0, '0, 1'b1);
        check("skew_drained", 64'(level), 64'd0);

        // Burst and fill: 6 vectors, no pops -> 4 kept, 2 dropped
        do_reset(1'b0);
        for (int k = 0; k < 6; k++) tick(1'b1, mk(k), 1'b0);
        for (int i = 0; i < 6; i++) tick(1'b0, '0, 1'b0);
        check("burst_level",    64'(level),    64'd4);
        check("burst_overflow", 64'(overflow), 64'd1);
        for (int k = 0; k < 4; k++) begin
            check("burst_pop_data", 64'(out_data), 64'(mk(k)));
            tick(1'b0, '0, 1'b1);
        end
        check("burst_empty",         64'(level),    64'd0);
        check("burst_overflow_held", 64'(overflow), 64'd1);

        // Full with simultaneous push and pop
        do_reset(1'b0);
        for (int k = 0; k < 4; k++) tick(1'b1, mk(k), 1'b0);
        for (int i = 0; i < 3; i++) tick(1'b0, '0, 1'b0);
        check("fpp_full", 64'(level), 64'd4);
        tick(1'b1, mk(9), 1'b0);
        tick(1'b0, '0, 1'b0);
        tick(1'b0, '0, 1'b0);
        tick(1'b0, '0, 1'b1);
        check("fpp_level",    64'(level),    64'd4);
        check("fpp_overflow", 64'(overflow), 64'd0);
        check("fpp_head",     64'(out_data), 64'(mk(1)));
        for (int i = 0; i < 6; i++) tick(1'b0, '0, 1'b1);

        // Frame marking: 10 vectors, continuous pops
        do_reset(1'b1);
        pops = 0;
        fd_seen = 0;
        prev_last_pop = 1'b0;
        for (int i = 0; i < 20; i++) begin
            check("frame_done_timing", 64'(frame_done), 64'(prev_last_pop));
            if (frame_done) fd_seen++;
            if (out_valid) begin
                pops++;
                check("frame_out_last", 64'(out_last), 64'((pops % FL) == 0));
            end
            prev_last_pop = out_valid && out_last;
            tick(i < 10, mk(i + 32), 1'b1);
        end
        check("frame_pops",     64'(pops),    64'd10);
        check("frame_done_cnt", 64'(fd_seen), 64'd2);

        // Reset with 3 vectors queued and 2 in the deskew pipeline
        do_reset(1'b0);
        for (int k = 0; k < 3; k++) tick(1'b1, mk(k + 48), 1'b0);
        for (int i = 0; i < 4; i++) tick(1'b0, '0, 1'b0);
        check("mid_level_before", 64'(level), 64'd3);
        tick(1'b1, mk(7), 1'b0);
        rst = 1'b0;
        tick(1'b1, mk(8), 1'b0);
        rst = 1'b1;
        check("mid_level",     64'(level),     64'd0);
        check("mid_out_valid", 64'(out_valid), 64'd0);
        check("mid_out_data",  64'(out_data),  64'd0);
        check("mid_overflow",  64'(overflow),  64'd0);
        for (int i = 0; i < 5; i++) begin
            tick(1'b0, '0, 1'b0);
            check("mid_quiet", 64'(out_valid), 64'd0);
        end

        // ReLU vector (lane3..lane0 = 0003, 8000, 7FFF, FFFF)
        rv = {16'h0003, 16'h8000, 16'h7FFF, 16'hFFFF};
        tick(1'b1, rv, 1'b1);
        for (int i = 0; i < 3; i++) tick(1'b0, '0, 1'b1);
`ifdef NPU_COLLECT_RELU_EN
        check("relu_data", 64'(out_data), 64'h0003_0000_7FFF_0000);
`else
        check("relu_data", 64'(out_data), 64'h0003_8000_7FFF_FFFF);
`endif
        tick(1'b0, '0, 1'b1);

        // Mixed traffic with a back-pressure window, checked by the model
        for (int i = 0; i < 60; i++) begin
            tick((i < 50) && (i % 5 != 2), mk(i + 64),
                 ((i >= 20) && (i < 30)) ? 1'b0 : (i % 3 != 0));
        end
        for (int i = 0; i < 12; i++) tick(1'b0, '0, 1'b1);
        check("mixed_drained", 64'(level), 64'd0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
